// File: rtl/memory_dma_copy_if.sv
// memory_dma_copy_if: register-side request/status and BRAM-port signals of
// the block-copy/fill engine, bundled for a single port connection.
//   start/mode/src_addr/dst_addr/length/fill_data : request from the CPU side
//   busy/done                                     : status back to the CPU side
//   mem_wr/mem_addr/mem_din/mem_dout              : single BRAM port
// Modports: master = the DMA engine, slave = the CPU + BRAM environment.
interface memory_dma_copy_if #(
    parameter int data_size = 8,
    parameter int addr_size = 8
);
    logic                 start;
    logic                 mode;
    logic [addr_size-1:0] src_addr;
    logic [addr_size-1:0] dst_addr;
    logic [addr_size:0]   length;
    logic [data_size-1:0] fill_data;
    logic                 busy;
    logic                 done;
    logic                 mem_wr;
    logic [addr_size-1:0] mem_addr;
    logic [data_size-1:0] mem_din;
    logic [data_size-1:0] mem_dout;

    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_data, mem_dout,
        output busy, done, mem_wr, mem_addr, mem_din
    );

    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_data, mem_dout,
        input  busy, done, mem_wr, mem_addr, mem_din
    );
endinterface

// File: rtl/memory_dma_copy.sv
// memory_dma_copy: single-port BRAM initiator that copies a block of words
// (READ/WRITE pairs, 2 cycles/word) or fills a range with a constant
// (1 cycle/word). Addresses wrap modulo the memory depth.
// Ports:
//   clk   : clock for the engine and the BRAM port it drives
//   rst_n : asynchronous active-low reset; aborts any transfer at once
//   bus   : memory_dma_copy_if.master (request, status, BRAM port)
module memory_dma_copy #(
    parameter int data_size = 8,
    parameter int addr_size = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    memory_dma_copy_if.master       bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t               state, state_nxt;
    logic                 mode_q;
    logic [addr_size-1:0] src_q;
    logic [addr_size-1:0] dst_q;
    logic [addr_size:0]   len_q;
    logic [data_size-1:0] fill_q;
    // one bit wider than an address so length = 2**addr_size is reachable
    logic [addr_size:0]   i_q;
    logic [addr_size:0]   i_inc;

    assign i_inc = i_q + {{addr_size{1'b0}}, 1'b1};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // operand latches and word index; operands only move on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            i_q    <= '0;
        end else if (state == IDLE && bus.start) begin
            mode_q <= bus.mode;
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            len_q  <= bus.length;
            fill_q <= bus.fill_data;
            i_q    <= '0;
        end else if (state == WRITE) begin
            i_q <= i_inc;
        end
    end

    // next-state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) state_nxt = FINISH;
                    else if (bus.mode)    state_nxt = WRITE;
                    else                  state_nxt = READ;
                end
            end
            READ:  state_nxt = WRITE;
            WRITE: begin
                if (i_inc == len_q) state_nxt = FINISH;
                else if (mode_q)    state_nxt = WRITE;
                else                state_nxt = READ;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: address/strobe decoded from registered state and counters;
    // write data is a pure mux so read data reaches the write port same cycle
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = mode_q ? fill_q : bus.mem_dout;
        case (state)
            READ: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_q + i_q[addr_size-1:0];
            end
            WRITE: begin
                bus.busy     = 1'b1;
                bus.mem_wr   = 1'b1;
                bus.mem_addr = dst_q + i_q[addr_size-1:0];
            end
            FINISH:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_memory_dma_copy.sv
// tb_memory_dma_copy: directed bench for memory_dma_copy with a write-first
// BRAM model, a write/busy/done monitor and hand-computed expectations.
module tb_memory_dma_copy;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_dma_copy_if #(.data_size(8), .addr_size(8)) bus ();

    memory_dma_copy #(.data_size(8), .addr_size(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // BRAM model: registered read, write-first; a side preload port for the bench
    logic [7:0] mem [256];
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout      <= bus.mem_din;
        end else begin
            bus.mem_dout <= mem[bus.mem_addr];
            if (pl_we) mem[pl_addr] <= pl_data;
        end
    end

    // monitor: sampled on the falling edge, away from the active edge
    int         cyc = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    logic [7:0] wr_addr_q[$];
    int         wr_cyc_q[$];

    always @(negedge clk) begin
        if (bus.mem_wr) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        cyc++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic kick(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] len, input logic [7:0] f);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.src_addr = s;
        bus.dst_addr = d; bus.length = len; bus.fill_data = f;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // waits for done (bounded), then one more falling edge so the monitor has settled
    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 700; k++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        if (k == 700) chk({tag, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    // snapshot bases so each operation is judged on its own writes
    int wb, bb, db;
    task automatic snap();
        wb = wr_addr_q.size(); bb = busy_cnt; db = done_cnt;
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.length = '0; bus.fill_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wr",   bus.mem_wr, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst_n = 1'b1;

        for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);

        // fill 0x10..0x13 with A5
        snap();
        kick(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5);
        wait_done("fill");
        chk("fill_nwr", wr_addr_q.size() - wb, 4);
        for (int k = 0; k < 4; k++) chk("fill_addr", wr_addr_q[wb+k], 32'h10 + k);
        chk("fill_consec", wr_cyc_q[wb+3] - wr_cyc_q[wb], 3);
        chk("fill_busy", busy_cnt - bb, 4);
        chk("fill_done", done_cnt - db, 1);
        for (int k = 0; k < 4; k++) chk("fill_mem", mem[8'h10 + k], 8'hA5);
        chk("fill_below", mem[8'h0F], 8'h00);
        chk("fill_above", mem[8'h14], 8'h00);

        // copy 0x20..0x22 -> 0x40..0x42
        preload(8'h20, 8'h11); preload(8'h21, 8'h22); preload(8'h22, 8'h33);
        snap();
        kick(1'b0, 8'h20, 8'h40, 9'd3, 8'hFF);
        wait_done("copy");
        chk("copy_nwr", wr_addr_q.size() - wb, 3);
        chk("copy_busy", busy_cnt - bb, 6);
        chk("copy_gap", wr_cyc_q[wb+1] - wr_cyc_q[wb], 2);
        chk("copy_m0", mem[8'h40], 8'h11);
        chk("copy_m1", mem[8'h41], 8'h22);
        chk("copy_m2", mem[8'h42], 8'h33);
        chk("copy_done_lat", last_done_cyc - wr_cyc_q[wb+2], 1);

        // fill wrapping from the top of memory
        snap();
        kick(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A);
        wait_done("wrap");
        chk("wrap_nwr", wr_addr_q.size() - wb, 4);
        chk("wrap_a0", wr_addr_q[wb],   8'hFE);
        chk("wrap_a1", wr_addr_q[wb+1], 8'hFF);
        chk("wrap_a2", wr_addr_q[wb+2], 8'h00);
        chk("wrap_a3", wr_addr_q[wb+3], 8'h01);
        chk("wrap_m", mem[8'h01], 8'h5A);
        chk("wrap_untouched", mem[8'h02], 8'h00);

        // length 0
        snap();
        kick(1'b1, 8'h00, 8'h30, 9'd0, 8'hEE);
        chk("len0_done_now", bus.done, 1);
        wait_done("len0");
        chk("len0_nwr", wr_addr_q.size() - wb, 0);
        chk("len0_busy", busy_cnt - bb, 0);
        chk("len0_done", done_cnt - db, 1);

        // start while busy is ignored
        snap();
        kick(1'b0, 8'h20, 8'h60, 9'd8, 8'h00);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.dst_addr = 8'h80;
        bus.length = 9'd2; bus.fill_data = 8'hCC;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign");
        chk("ign_nwr", wr_addr_q.size() - wb, 8);
        for (int k = 0; k < 8; k++) chk("ign_addr", wr_addr_q[wb+k], 32'h60 + k);
        chk("ign_busy", busy_cnt - bb, 16);
        chk("ign_m80", mem[8'h80], 8'h00);
        chk("ign_m61", mem[8'h61], 8'h22);

        // full memory fill
        snap();
        kick(1'b1, 8'h00, 8'h00, 9'd256, 8'h3C);
        wait_done("full");
        chk("full_nwr", wr_addr_q.size() - wb, 256);
        chk("full_busy", busy_cnt - bb, 256);
        chk("full_done", done_cnt - db, 1);
        begin
            int bad = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== 8'h3C) bad++;
            chk("full_bad_words", bad, 0);
        end

        // reset after the 3rd write of an 8-word copy
        for (int k = 0; k < 8; k++) preload(8'(8'h20 + k), 8'(k + 1));
        kick(1'b0, 8'h20, 8'h50, 9'd8, 8'h00);
        begin
            int nw = 0;
            for (int k = 0; k < 100 && nw < 3; k++) begin
                if (bus.mem_wr) nw++;
                if (nw < 3) @(negedge clk);
            end
            chk("rmid_reached3", nw, 3);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_busy", bus.busy, 0);
        chk("rmid_wr",   bus.mem_wr, 0);
        chk("rmid_done", bus.done, 0);
        repeat (3) @(negedge clk);
        chk("rmid_m52", mem[8'h52], 8'h03);
        chk("rmid_m53", mem[8'h53], 8'h3C);
        chk("rmid_m57", mem[8'h57], 8'h3C);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_idle", bus.busy, 0);
        snap();
        kick(1'b1, 8'h00, 8'h90, 9'd2, 8'h77);
        wait_done("rmid_new");
        chk("rmid_new_nwr", wr_addr_q.size() - wb, 2);
        chk("rmid_new_m90", mem[8'h90], 8'h77);
        chk("rmid_new_m91", mem[8'h91], 8'h77);
        chk("rmid_new_m92", mem[8'h92], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
